div_32bit: RTL and testbench
============================

Name: div_32bit

Overview:
- Multi-cycle signed 32-bit integer divider in the multdiv unit.
- Sits directly downstream of the 32-bit two's-complement negation stage.
- Uses negate_32bit instances to form operand magnitudes, runs a 32-iteration restoring division, then negates the quotient when the operand signs differ.
- Reports result-ready and divide-by-zero to the multdiv controller.

Parameters:
- None. The datapath is fixed at 32 bits and the iteration count is fixed at 32.

Ports:
- clock  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- ctrl_DIV  input  1  start pulse; operands sampled on the edge where ctrl_DIV=1
- data_operandA  input  32  dividend, signed two's complement
- data_operandB  input  32  divisor, signed two's complement
- data_result  output  32  signed quotient, truncated toward zero
- data_exception  output  1  1 = divide by zero (valid while data_resultRDY=1)
- data_resultRDY  output  1  one-cycle pulse when data_result and data_exception are valid

Behaviour:
- Reset: the interface is one clock with an asynchronous, active-high reset.
  - While reset=1, state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, and all internal registers are 0.
  - Reset asserted mid-operation aborts the operation; no resultRDY pulse is produced.
- States: IDLE, RUN, DONE.
  - IDLE: outputs hold their last values; resultRDY=0.
  - ctrl_DIV=1 on edge k latches the following:
    - |A| via a negate stage with negate=A[31];
    - |B| via a negate stage with negate=B[31];
    - sign_q = A[31]^B[31];
    - dbz = (B==0).
  - The same edge clears the 64-bit working register {R[31:0],Q[31:0]} to {0,|A|} and the counter to 0, then goes to RUN.
  - RUN, each edge k+1..k+32:
    - shift {R,Q} left by 1;
    - T = R_shifted - |B| as a 33-bit subtract;
    - if T is non-negative, R=T[31:0] and Q[0]=1;
    - otherwise R is unchanged and Q[0]=0;
    - counter++.
    - After counter reaches 32, go to DONE.
  - DONE, on edge k+33:
    - data_result = dbz ? 0 : (sign_q ? -Q : Q);
    - the final negation uses a negate stage;
    - data_exception=dbz;
    - data_resultRDY=1 for exactly this cycle;
    - next edge returns to IDLE.
- Latency: 33 cycles from the sampling edge to resultRDY high.
  - Output is visible in the cycle after edge k+33.
  - Back-to-back operations are allowed: ctrl_DIV may be asserted in the resultRDY cycle.
- ctrl_DIV=1 while in RUN or DONE restarts with the new operands (same as from IDLE). The in-flight result is discarded, and no resultRDY pulse is produced for it.
- Divide by zero:
  - takes the full 33-cycle latency;
  - result forced to 0x00000000 with exception=1;
  - the dividend value is irrelevant.
- Magnitudes are treated as unsigned 32-bit. |0x80000000| = 0x80000000 is correct unsigned.
- -2^31 / -1 produces quotient 0x80000000 (wraps), exception=0.
- Remainder is not an output.
- data_result and data_exception hold their values after the pulse until the next DONE or reset.

Test Plan:
- Positive division: reset, then A=100, B=7, ctrl_DIV pulse -> exactly 33 cycles later resultRDY=1 for 1 cycle, result=0x0000000E, exception=0.
- Signed cases (truncation toward zero):
  - A=-100 (0xFFFFFF9C), B=7 -> result=0xFFFFFFF2 (-14);
  - A=-100, B=-7 -> result=14;
  - A=7, B=-100 -> result=0.
- Divide by zero: A=0x12345678, B=0 -> after 33 cycles resultRDY=1, exception=1, result=0.
- Edge values:
  - A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=0;
  - A=0x7FFFFFFF, B=1 -> result=0x7FFFFFFF.
- Restart: start A=50, B=5, then at cycle 10 pulse ctrl_DIV with A=9, B=3 -> single resultRDY pulse 33 cycles after the second pulse with result=3; no pulse for the first operation.
- Reset mid-operation: assert reset asynchronously (between edges) at cycle 15 of a division -> outputs 0 immediately. With no new ctrl_DIV, resultRDY never pulses. A new operation after release completes normally.

Source files
------------

// File: rtl/negate_32bit.sv
`default_nettype none
// ============================================================================
// Module      : negate_32bit
// Description : Conditional 32-bit two's-complement negation.
//               data_out = negate ? (~data_in + 1) : data_in
//               Implemented as a conditional invert followed by a ripple
//               increment whose carry-in is the negate flag.
// Ports       : data_in   [31:0] in   value to pass through or negate
//               negate           in   1 = negate, 0 = pass through
//               data_out  [31:0] out  result (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module negate_32bit (
    input  logic [31:0] data_in,
    input  logic        negate,
    output logic [31:0] data_out
);

    logic [31:0] w_inv;
    logic [32:0] w_carry;

    assign w_inv      = negate ? ~data_in : data_in;
    assign w_carry[0] = negate;

    // Ripple increment: adding the carry-in (the negate flag) to the
    // inverted value completes the two's-complement.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi = gi + 1) begin : g_bit
            assign data_out[gi]    = w_inv[gi] ^ w_carry[gi];
            assign w_carry[gi + 1] = w_inv[gi] & w_carry[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/div_32bit.sv
`default_nettype none
// ============================================================================
// Module      : div_32bit
// Description : Multi-cycle signed 32-bit integer divider (quotient only).
//               Operand magnitudes are formed with negate_32bit stages, a
//               32-iteration restoring division runs on the magnitudes, and
//               the quotient is negated when the operand signs differ.
//               Result is truncated toward zero; divide by zero returns 0
//               with the exception flag set. Latency: 33 clocks from the
//               sampling edge to data_resultRDY.
// Ports       : clock                 in   system clock (rising edge)
//               reset                 in   asynchronous active-high reset
//               ctrl_DIV              in   start pulse, samples operands
//               data_operandA  [31:0] in   dividend (signed)
//               data_operandB  [31:0] in   divisor  (signed)
//               data_result    [31:0] out  signed quotient
//               data_exception        out  1 = divide by zero
//               data_resultRDY        out  one-cycle result-valid pulse
// Revision    : 1.0 - initial release
// ============================================================================
module div_32bit (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter value on the edge that performs the final (32nd) iteration.
    localparam logic [5:0] c_LAST_ITER = 6'd31;

    state_t      r_state;
    state_t      w_state_next;

    logic [5:0]  r_count;
    logic [31:0] r_rem;        // partial remainder R
    logic [31:0] r_quo;        // dividend magnitude shifting out / quotient in
    logic [31:0] r_mag_b;      // divisor magnitude
    logic        r_sign_q;
    logic        r_dbz;

    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_quo_signed;
    logic [63:0] w_shift;
    logic [32:0] w_diff;

    // ------------------------------------------------------------------------
    // Magnitude and sign-correction stages
    // ------------------------------------------------------------------------
    negate_32bit u_neg_a (
        .data_in  (data_operandA),
        .negate   (data_operandA[31]),
        .data_out (w_mag_a)
    );

    negate_32bit u_neg_b (
        .data_in  (data_operandB),
        .negate   (data_operandB[31]),
        .data_out (w_mag_b)
    );

    negate_32bit u_neg_q (
        .data_in  (r_quo),
        .negate   (r_sign_q),
        .data_out (w_quo_signed)
    );

    // ------------------------------------------------------------------------
    // One restoring-division step. R < |B| <= 2^31 holds before every step,
    // so the shifted remainder always fits in 32 bits and the 33-bit subtract
    // sign bit alone tells whether |B| fits.
    // ------------------------------------------------------------------------
    assign w_shift = {r_rem, r_quo} << 1;
    assign w_diff  = {1'b0, w_shift[63:32]} - {1'b0, r_mag_b};

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic. A start pulse in any state (re)starts the
    // operation, discarding whatever was in flight.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (ctrl_DIV) begin
            w_state_next = S_RUN;
        end else begin
            case (r_state)
                S_IDLE:  w_state_next = S_IDLE;
                S_RUN:   w_state_next = (r_count == c_LAST_ITER) ? S_DONE : S_RUN;
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count        <= 6'd0;
            r_rem          <= 32'd0;
            r_quo          <= 32'd0;
            r_mag_b        <= 32'd0;
            r_sign_q       <= 1'b0;
            r_dbz          <= 1'b0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            // Ready is a single-cycle pulse; only the DONE edge raises it.
            data_resultRDY <= 1'b0;

            if (ctrl_DIV) begin
                r_rem    <= 32'd0;
                r_quo    <= w_mag_a;
                r_mag_b  <= w_mag_b;
                r_sign_q <= data_operandA[31] ^ data_operandB[31];
                r_dbz    <= (data_operandB == 32'd0);
                r_count  <= 6'd0;
            end else begin
                case (r_state)
                    S_RUN: begin
                        if (!w_diff[32]) begin
                            r_rem <= w_diff[31:0];
                            r_quo <= {w_shift[31:1], 1'b1};
                        end else begin
                            r_rem <= w_shift[63:32];
                            r_quo <= {w_shift[31:1], 1'b0};
                        end
                        r_count <= r_count + 6'd1;
                    end
                    S_DONE: begin
                        data_result    <= r_dbz ? 32'd0 : w_quo_signed;
                        data_exception <= r_dbz;
                        data_resultRDY <= 1'b1;
                    end
                    default: begin
                        // IDLE: hold results until the next DONE or reset.
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_32bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_32bit
// Description : Self-checking bench for div_32bit. Expected results are
//               computed from a behavioural signed-division model, queued
//               when an operation is launched, and compared (value,
//               exception, latency) when data_resultRDY pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_32bit;

    logic        clock;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          issue;
    } exp_t;

    exp_t sb[$];
    exp_t r_mon;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    div_32bit u_dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, req, $time);
        end
    endtask

    // Reference model: signed division truncating toward zero.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int issue);
        exp_t e;
        e.issue = issue;
        if (b == 32'd0) begin
            e.res = 32'd0;
            e.exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = 32'h8000_0000;
            e.exc = 1'b0;
        end else begin
            e.res = $signed(a) / $signed(b);
            e.exc = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard consumer: every ready pulse must match the oldest
    // outstanding operation and arrive exactly 33 edges after its start.
    always @(negedge clock) begin
        if (data_resultRDY) begin
            if (sb.size() == 0) begin
                check_eq("spurious_rdy", {63'd0, data_resultRDY}, 64'd0);
            end else begin
                r_mon = sb.pop_front();
                check_eq("result",    {32'd0, data_result},    {32'd0, r_mon.res});
                check_eq("exception", {63'd0, data_exception}, {63'd0, r_mon.exc});
                check_eq("latency",   64'(cyc - r_mon.issue),  64'd33);
            end
        end
    end

    // Drive a one-edge start pulse; call between a negedge and the next posedge.
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        sb.push_back(model(a, b, cyc + 1));
        @(negedge clock);
        #1;
        ctrl_DIV      = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && sb.size() != 0; i++) begin
            @(negedge clock);
            #2;
        end
        check_eq("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b);
        start(a, b);
        wait_idle();
    endtask

    initial begin
        logic seen;
        reset         = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        repeat (3) @(negedge clock);
        #1;
        check_eq("rst_result", {32'd0, data_result},    64'd0);
        check_eq("rst_exc",    {63'd0, data_exception}, 64'd0);
        check_eq("rst_rdy",    {63'd0, data_resultRDY}, 64'd0);
        reset = 1'b0;
        @(negedge clock);
        #1;

        // Directed cases
        run(32'd100,        32'd7);
        run(32'hFFFF_FF9C,  32'd7);
        run(32'hFFFF_FF9C,  32'hFFFF_FFF9);
        run(32'd7,          32'hFFFF_FF9C);
        run(32'h1234_5678,  32'd0);
        // Results must hold after the pulse
        repeat (3) @(negedge clock);
        #1;
        check_eq("hold_exc",    {63'd0, data_exception}, 64'd1);
        check_eq("hold_result", {32'd0, data_result},    64'd0);
        run(32'h8000_0000,  32'hFFFF_FFFF);
        run(32'h7FFF_FFFF,  32'd1);
        run(32'h8000_0000,  32'h8000_0000);
        run(32'd0,          32'd5);
        run(32'hFFFF_FFFF,  32'd2);

        // Random cases
        for (int i = 0; i < 6; i++) begin
            run($urandom, (i % 2 == 0) ? $urandom : $urandom_range(1, 50));
        end

        // Back-to-back: start again in the ready cycle
        start(32'd1000, 32'd10);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clock);
            #1;
            if (data_resultRDY) seen = 1'b1;
        end
        check_eq("b2b_seen", {63'd0, seen}, 64'd1);
        start(32'hFFFF_FC18, 32'd10);
        wait_idle();

        // Restart mid-operation: the first operation must not report
        start(32'd50, 32'd5);
        repeat (9) @(negedge clock);
        #1;
        void'(sb.pop_back());
        start(32'd9, 32'd3);
        wait_idle();

        // Asynchronous reset mid-operation
        start(32'd1000, 32'd3);
        repeat (14) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_result", {32'd0, data_result},    64'd0);
        check_eq("mid_rst_exc",    {63'd0, data_exception}, 64'd0);
        check_eq("mid_rst_rdy",    {63'd0, data_resultRDY}, 64'd0);
        sb.delete();
        @(negedge clock);
        #1;
        reset = 1'b0;
        repeat (45) @(negedge clock);
        #1;
        check_eq("post_rst_result", {32'd0, data_result}, 64'd0);
        run(32'hFFFF_FFAF, 32'd9);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
